// File: rtl/btn_pkg.sv
// Shared types and width helpers for the multi-channel button debouncer.
package btn_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      PRESSED   = 2'd1,
      LONG_HELD = 2'd2
   } btn_state_t;

   localparam int MIN_CNT_W = 1;

   // Bits needed to hold values 0..max_count, never narrower than one bit.
   function automatic int cnt_width(input int max_count);
      int w;
      w = $clog2(max_count + 1);
      return (w < MIN_CNT_W) ? MIN_CNT_W : w;
   endfunction

endpackage

// File: rtl/btn_debounce_chan.sv
// One button channel: synchroniser, no-partial-credit debounce counter and
// press/long-hold FSM producing registered level and strobes.
module btn_debounce_chan
   import btn_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int LONG_CYCLES     = 100000000,
   parameter int ACTIVE_LOW      = 0
) (
   input  logic Clk,
   input  logic Reset,
   input  logic btn_in,
   output logic btn_level,
   output logic btn_press,
   output logic btn_release,
   output logic btn_long
);

   localparam int DB_W   = cnt_width(DEBOUNCE_CYCLES);
   localparam int HOLD_W = cnt_width(LONG_CYCLES);
   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
   localparam logic              RAW_IDLE  = (ACTIVE_LOW != 0);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
   logic                   level_q, level_d;
   logic                   accept;
   btn_state_t             state_q, state_d;
   logic [HOLD_W-1:0]      hold_q, hold_d;
   logic                   press_q, press_d;
   logic                   release_q, release_d;
   logic                   long_q, long_d;

   // Polarity is normalised after the last synchroniser stage: s = 1 means pressed.
   assign s = sync_q[SYNC_STAGES-1] ^ RAW_IDLE;

   always_comb begin
      db_cnt_d = db_cnt_q;
      level_d  = level_q;
      accept   = 1'b0;
      if (s == level_q) begin
         db_cnt_d = '0;
      end else if (db_cnt_q == DB_LAST) begin
         accept   = 1'b1;
         level_d  = s;
         db_cnt_d = '0;
      end else begin
         db_cnt_d = db_cnt_q + DB_W'(1);
      end
   end

   // Strobes are computed from the acceptance so they line up with the level change.
   always_comb begin
      state_d   = state_q;
      hold_d    = hold_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      long_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept && s) begin
               state_d = PRESSED;
               hold_d  = '0;
               press_d = 1'b1;
            end
         end
         PRESSED: begin
            if (accept && !s) begin
               state_d   = IDLE;
               release_d = 1'b1;
            end else if (hold_q == HOLD_LAST) begin
               state_d = LONG_HELD;
               long_d  = 1'b1;
            end else begin
               hold_d = hold_q + HOLD_W'(1);
            end
         end
         LONG_HELD: begin
            if (accept && !s) begin
               state_d   = IDLE;
               release_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         sync_q    <= {SYNC_STAGES{RAW_IDLE}};
         db_cnt_q  <= '0;
         level_q   <= 1'b0;
         state_q   <= IDLE;
         hold_q    <= '0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         long_q    <= 1'b0;
      end else begin
         sync_q    <= {sync_q[SYNC_STAGES-2:0], btn_in};
         db_cnt_q  <= db_cnt_d;
         level_q   <= level_d;
         state_q   <= state_d;
         hold_q    <= hold_d;
         press_q   <= press_d;
         release_q <= release_d;
         long_q    <= long_d;
      end
   end

   assign btn_level   = level_q;
   assign btn_press   = press_q;
   assign btn_release = release_q;
   assign btn_long    = long_q;

endmodule

// File: rtl/btn_debounce_multi.sv
// N independent debounced button channels with press, release and long-press strobes.
module btn_debounce_multi
   import btn_pkg::*;
#(
   parameter int NUM_BTN         = 4,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int LONG_CYCLES     = 100000000,
   parameter int ACTIVE_LOW      = 0
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic [NUM_BTN-1:0] btn_in,
   output logic [NUM_BTN-1:0] btn_level,
   output logic [NUM_BTN-1:0] btn_press,
   output logic [NUM_BTN-1:0] btn_release,
   output logic [NUM_BTN-1:0] btn_long
);

   for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
      btn_debounce_chan #(
         .SYNC_STAGES    (SYNC_STAGES),
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .LONG_CYCLES    (LONG_CYCLES),
         .ACTIVE_LOW     (ACTIVE_LOW)
      ) u_chan (
         .Clk        (Clk),
         .Reset      (Reset),
         .btn_in     (btn_in[g]),
         .btn_level  (btn_level[g]),
         .btn_press  (btn_press[g]),
         .btn_release(btn_release[g]),
         .btn_long   (btn_long[g])
      );
   end

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Bench for btn_debounce_multi: active-high and active-low instances driven with
// complementary pins, both checked every cycle against a run-length reference model.
module tb_btn_debounce_multi;

   localparam int NB = 2;
   localparam int SS = 2;
   localparam int DB = 4;
   localparam int LC = 10;

   logic          Clk = 1'b0;
   logic          Reset;
   logic [NB-1:0] btn;
   logic [NB-1:0] btn_n;
   logic [NB-1:0] lvl_a, prs_a, rel_a, lng_a;
   logic [NB-1:0] lvl_b, prs_b, rel_b, lng_b;

   assign btn_n = ~btn;

   btn_debounce_multi #(
      .NUM_BTN(NB), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB), .LONG_CYCLES(LC), .ACTIVE_LOW(0)
   ) u_dut_hi (
      .Clk(Clk), .Reset(Reset), .btn_in(btn),
      .btn_level(lvl_a), .btn_press(prs_a), .btn_release(rel_a), .btn_long(lng_a)
   );

   btn_debounce_multi #(
      .NUM_BTN(NB), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB), .LONG_CYCLES(LC), .ACTIVE_LOW(1)
   ) u_dut_lo (
      .Clk(Clk), .Reset(Reset), .btn_in(btn_n),
      .btn_level(lvl_b), .btn_press(prs_b), .btn_release(rel_b), .btn_long(lng_b)
   );

   always #5 Clk = ~Clk;

   // Reference model: pin delay line, run length of the synchronised value, level, hold age.
   bit            syncm [NB][SS];
   int            runm  [NB];
   bit            m_lvl [NB];
   int            age   [NB];
   bit            long_done [NB];
   logic [NB-1:0] e_lvl, e_prs, e_rel, e_lng;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int base;
   int ev_press [NB], ev_rel [NB], ev_long [NB];
   int first_press [NB], first_rel [NB], first_long [NB];
   int dur [NB];

   task automatic clear_ev();
      for (int ch = 0; ch < NB; ch++) begin
         ev_press[ch] = 0; ev_rel[ch] = 0; ev_long[ch] = 0;
         first_press[ch] = -1; first_rel[ch] = -1; first_long[ch] = -1;
      end
   endtask

   task automatic model_edge();
      bit s;
      for (int ch = 0; ch < NB; ch++) begin
         e_prs[ch] = 1'b0; e_rel[ch] = 1'b0; e_lng[ch] = 1'b0;
         if (Reset) begin
            for (int k = 0; k < SS; k++) syncm[ch][k] = 1'b0;
            runm[ch] = 1; m_lvl[ch] = 1'b0; age[ch] = 0; long_done[ch] = 1'b0;
         end else begin
            s = syncm[ch][SS-1];
            if (s != m_lvl[ch] && runm[ch] >= DB) begin
               m_lvl[ch] = s;
               if (s) e_prs[ch] = 1'b1; else e_rel[ch] = 1'b1;
               age[ch] = 0; long_done[ch] = 1'b0;
            end else if (m_lvl[ch]) begin
               age[ch]++;
               if (age[ch] == LC && !long_done[ch]) begin
                  e_lng[ch] = 1'b1; long_done[ch] = 1'b1;
               end
            end
            for (int k = SS - 1; k > 0; k--) syncm[ch][k] = syncm[ch][k-1];
            syncm[ch][0] = btn[ch];
            runm[ch] = (syncm[ch][SS-1] == s) ? runm[ch] + 1 : 1;
         end
         e_lvl[ch] = m_lvl[ch];
         if (e_prs[ch]) begin ev_press[ch]++; if (first_press[ch] < 0) first_press[ch] = cyc; end
         if (e_rel[ch]) begin ev_rel[ch]++;   if (first_rel[ch] < 0)   first_rel[ch]   = cyc; end
         if (e_lng[ch]) begin ev_long[ch]++;  if (first_long[ch] < 0)  first_long[ch]  = cyc; end
      end
   endtask

   task automatic check_vec(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
      cyc++;
      model_edge();
      check_vec("level_hi",   lvl_a, e_lvl);
      check_vec("press_hi",   prs_a, e_prs);
      check_vec("release_hi", rel_a, e_rel);
      check_vec("long_hi",    lng_a, e_lng);
      check_vec("level_lo",   lvl_b, e_lvl);
      check_vec("press_lo",   prs_b, e_prs);
      check_vec("release_lo", rel_b, e_rel);
      check_vec("long_lo",    lng_b, e_lng);
   endtask

   initial begin
      Reset = 1'b1;
      btn   = '0;
      clear_ev();
      repeat (3) step();
      check_vec("reset_level", lvl_a, 2'b00);
      Reset = 1'b0;
      step();

      // Clean press and hold into long press.
      clear_ev(); base = cyc; btn[0] = 1'b1;
      repeat (40) step();
      check_int("s1_press_at",    first_press[0] - base, 6);
      check_int("s1_long_at",     first_long[0] - base, 16);
      check_int("s1_long_count",  ev_long[0], 1);
      check_int("s1_press_count", ev_press[0], 1);

      // Release after long press.
      clear_ev(); base = cyc; btn[0] = 1'b0;
      repeat (15) step();
      check_int("s3_release_at",  first_rel[0] - base, 6);
      check_int("s3_long_count",  ev_long[0], 0);

      // Bounce shorter than the debounce window.
      clear_ev();
      for (int i = 0; i < 20; i++) begin
         btn[0] = ((i / 3) % 2 == 0);
         step();
      end
      btn[0] = 1'b0;
      repeat (15) step();
      check_int("s2_press_count",   ev_press[0], 0);
      check_int("s2_release_count", ev_rel[0], 0);

      // Short hold: released before the long threshold.
      clear_ev(); base = cyc; btn[0] = 1'b1;
      repeat (8) step();
      btn[0] = 1'b0;
      repeat (20) step();
      check_int("s4_press_count",   ev_press[0], 1);
      check_int("s4_release_at",    first_rel[0] - base, 14);
      check_int("s4_long_count",    ev_long[0], 0);

      // Independent channels two cycles apart, then reset while both are held.
      clear_ev(); base = cyc; btn[0] = 1'b1;
      repeat (2) step();
      btn[1] = 1'b1;
      repeat (20) step();
      check_int("s5_press0_at", first_press[0] - base, 6);
      check_int("s5_press1_at", first_press[1] - base, 8);
      clear_ev();
      Reset = 1'b1;
      step();
      check_vec("s5_reset_level", lvl_a, 2'b00);
      Reset = 1'b0; base = cyc;
      repeat (15) step();
      check_int("s5_repress0_at", first_press[0] - base, 6);
      check_int("s5_repress1_at", first_press[1] - base, 6);
      check_int("s5_release0",    ev_rel[0], 0);
      check_int("s5_release1",    ev_rel[1], 0);

      // Randomised hold/bounce durations with occasional resets.
      for (int ch = 0; ch < NB; ch++) dur[ch] = 0;
      for (int i = 0; i < 1500; i++) begin
         for (int ch = 0; ch < NB; ch++) begin
            if (dur[ch] == 0) begin
               btn[ch] = ~btn[ch];
               dur[ch] = $urandom_range(25, 1);
            end
            dur[ch]--;
         end
         Reset = ($urandom_range(299, 0) == 0);
         step();
      end
      Reset = 1'b0;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
